linear_argmax: RTL

- Classification head placed directly downstream of the linear (fully-connected) stage.
- Captures the stage's packed output vector on its valid pulse.
- Scans the pOUT_FEATURE scores serially, one per clock, and reports the winning class index and its score with a one-cycle valid pulse.
- Serial scan keeps the design to one comparator, regardless of pOUT_FEATURE.

---
 rtl/linear_argmax.sv | 131 +++++++++++++
 1 files changed

// File: rtl/linear_argmax.sv
// linear_argmax: classification head behind a fully-connected stage.
// Captures one packed score vector, walks it one element per clock with a
// single comparator, and strobes out the winning index and its score.
module linear_argmax #(
   parameter int pDATA_WIDTH  = 8,
   parameter int pOUT_FEATURE = 10,
   parameter     pACTIVATION  = "sigmoid",
   parameter bit pSIGNED      = 1'b1,
   localparam int pELEM_WIDTH = (pACTIVATION == "softmax") ? 32 : pDATA_WIDTH,
   localparam int pIDX_WIDTH  = $clog2(pOUT_FEATURE)
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                en,
   input  logic                                data_valid,
   input  logic [pELEM_WIDTH*pOUT_FEATURE-1:0] data_in,
   output logic                                ready,
   output logic                                valid,
   output logic [pIDX_WIDTH-1:0]               class_idx,
   output logic [pELEM_WIDTH-1:0]              max_val
);

   localparam logic [pIDX_WIDTH-1:0] LAST = pIDX_WIDTH'(pOUT_FEATURE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                              state_q, state_d;
   logic [pIDX_WIDTH-1:0]               cnt_q, cnt_d;
   logic [pELEM_WIDTH*pOUT_FEATURE-1:0] cap_q, cap_d;
   logic [pELEM_WIDTH-1:0]              best_val_q, best_val_d;
   logic [pIDX_WIDTH-1:0]               best_idx_q, best_idx_d;
   logic [pIDX_WIDTH-1:0]               class_idx_q, class_idx_d;
   logic [pELEM_WIDTH-1:0]              max_val_q, max_val_d;
   logic                                valid_q, valid_d;

   logic [pELEM_WIDTH-1:0]              elem [pOUT_FEATURE];
   logic [pELEM_WIDTH-1:0]              cand_val;
   logic                                take;

   // Strict greater-than; the signedness is fixed at elaboration.
   function automatic logic is_greater(input logic [pELEM_WIDTH-1:0] a,
                                       input logic [pELEM_WIDTH-1:0] b);
      if (pSIGNED) return $signed(a) > $signed(b);
      else         return a > b;
   endfunction

   for (genvar k = 0; k < pOUT_FEATURE; k++) begin : g_unpack
      assign elem[k] = cap_q[k*pELEM_WIDTH +: pELEM_WIDTH];
   end

   // Next-state logic: capture in IDLE, one compare per SCAN cycle, one-cycle strobe in OUT.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_d       = cap_q;
      best_val_d  = best_val_q;
      best_idx_d  = best_idx_q;
      class_idx_d = class_idx_q;
      max_val_d   = max_val_q;
      valid_d     = valid_q;
      cand_val    = elem[cnt_q];
      take        = is_greater(cand_val, best_val_q);
      case (state_q)
         IDLE: begin
            if (data_valid) begin
               cap_d      = data_in;
               best_val_d = data_in[pELEM_WIDTH-1:0];
               best_idx_d = '0;
               cnt_d      = pIDX_WIDTH'(1);
               state_d    = SCAN;
            end
         end
         SCAN: begin
            // Ties keep the earlier (lower) index because only strictly greater replaces.
            if (take) begin
               best_val_d = cand_val;
               best_idx_d = cnt_q;
            end
            if (cnt_q == LAST) begin
               class_idx_d = best_idx_d;
               max_val_d   = best_val_d;
               valid_d     = 1'b1;
               state_d     = OUT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUT: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; everything freezes while en is low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cap_q       <= '0;
         best_val_q  <= '0;
         best_idx_q  <= '0;
         class_idx_q <= '0;
         max_val_q   <= '0;
         valid_q     <= 1'b0;
      end else if (en) begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_q       <= cap_d;
         best_val_q  <= best_val_d;
         best_idx_q  <= best_idx_d;
         class_idx_q <= class_idx_d;
         max_val_q   <= max_val_d;
         valid_q     <= valid_d;
      end
   end

   assign ready     = (state_q == IDLE);
   assign valid     = valid_q;
   assign class_idx = class_idx_q;
   assign max_val   = max_val_q;

endmodule
